// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD bus scheduler.
//   - HD44780 command byte constants
//   - scheduler state encoding
//   - is_long_cmd(): selects the long execution wait for clear/home commands
//   - init_byte(): power-up init sequence lookup
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment, no shift
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_HOME     = 8'h02;
  localparam logic [7:0] LCD_DDRAM    = 8'h80;

  localparam int INIT_LEN = 4;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT_LOAD,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } lcd_state_e;

  // 8'h03 decodes as "return home" on the controller (bit 0 is don't-care),
  // so it needs the long wait as well.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == LCD_CLEAR || data == LCD_HOME || data == 8'h03);
  endfunction

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_FUNC_SET;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_ENTRY;
      default: return LCD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_scheduler_if.sv
// lcd_bus_scheduler_if: requester handshake plus LCD pin bundle.
//   req/req_rs/req_data : per-requester pending byte (requester -> scheduler)
//   gnt                 : one-cycle acceptance pulse per requester
//   init_done           : init sequence finished
//   rs/rw/enable/data   : LCD pins driven by the scheduler
// Modports: master = requester side, slave = scheduler side.
interface lcd_bus_scheduler_if;
  import lcd_pkg::*;

  logic [1:0]  req;
  logic [1:0]  req_rs;
  logic [15:0] req_data;
  logic [1:0]  gnt;
  logic        init_done;
  logic        rs;
  logic        rw;
  logic        enable;
  logic [7:0]  data;

  modport master (
    output req, req_rs, req_data,
    input  gnt, init_done, rs, rw, enable, data
  );

  modport slave (
    input  req, req_rs, req_data,
    output gnt, init_done, rs, rw, enable, data
  );

endinterface

// File: rtl/lcd_rr_arbiter.sv
// lcd_rr_arbiter: 2-way round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req        : request vector
//   take       : the scheduler is accepting the current decision
//   gnt        : one-hot winner (combinational, zero when no request)
// The pointer names the requester that wins a tie; after any accepted
// grant it moves to the requester that did not win.
module lcd_rr_arbiter
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Winner 0 -> pointer 1, winner 1 -> pointer 0, i.e. gnt[0].
  always_ff @(posedge clk) begin
    if (reset)
      ptr <= 1'b0;
    else if (take && |req)
      ptr <= gnt[0];
  end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// lcd_bus_scheduler: owns an HD44780 8-bit write bus shared by two
// requesters. Runs the power-up init sequence, then arbitrates byte requests
// round-robin and drives each byte with setup / enable pulse / hold timing
// followed by the controller execution wait.
//   clk, reset : clock, synchronous active-high reset
//   bus        : lcd_bus_scheduler_if.slave (requests, grants, LCD pins)
// All outputs come straight from registers; rw is tied low (write-only).
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter int T_SETUP = 5,
  parameter int T_PULSE = 25,
  parameter int T_HOLD  = 5,
  parameter int T_SHORT = 2500,
  parameter int T_LONG  = 82000,
  parameter int T_PWRUP = 750000
) (
  input  logic                 clk,
  input  logic                 reset,
  lcd_bus_scheduler_if.slave   bus
);

  localparam int CNT_MAX = (T_PWRUP > T_LONG) ? T_PWRUP : T_LONG;
  localparam int CW      = $clog2(CNT_MAX + 1);

  lcd_state_e      state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      idx, idx_nxt;
  logic            rs_q, rs_nxt;
  logic [7:0]      data_q, data_nxt;
  logic            en_q, en_nxt;
  logic [1:0]      gnt_q, gnt_nxt;
  logic            done_q, done_nxt;
  logic [1:0]      arb_gnt;
  logic            take;
  logic            last;

  // One shared down-counter; a phase ends on the cycle it reads 1, so a
  // phase loaded with N lasts exactly N cycles.
  assign last = (cnt == CW'(1));

  lcd_rr_arbiter u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (bus.req),
    .take  (take),
    .gnt   (arb_gnt)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    rs_nxt    = rs_q;
    data_nxt  = data_q;
    en_nxt    = en_q;
    gnt_nxt   = 2'b00;
    done_nxt  = done_q;
    take      = 1'b0;

    case (state)
      S_PWRUP: begin
        if (last) begin
          state_nxt = S_INIT_LOAD;
          idx_nxt   = 2'd0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end

      S_INIT_LOAD: begin
        rs_nxt    = 1'b0;
        data_nxt  = init_byte(idx);
        cnt_nxt   = CW'(T_SETUP);
        state_nxt = S_SETUP;
      end

      // Requests are only looked at here, so a held req cannot be granted
      // twice and anything raised before init_done simply waits.
      S_IDLE: begin
        if (done_q && |bus.req) begin
          take      = 1'b1;
          gnt_nxt   = arb_gnt;
          rs_nxt    = arb_gnt[1] ? bus.req_rs[1] : bus.req_rs[0];
          data_nxt  = arb_gnt[1] ? bus.req_data[15:8] : bus.req_data[7:0];
          cnt_nxt   = CW'(T_SETUP);
          state_nxt = S_SETUP;
        end
      end

      S_SETUP: begin
        if (last) begin
          en_nxt    = 1'b1;
          cnt_nxt   = CW'(T_PULSE);
          state_nxt = S_PULSE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end

      S_PULSE: begin
        if (last) begin
          en_nxt    = 1'b0;
          cnt_nxt   = CW'(T_HOLD);
          state_nxt = S_HOLD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end

      S_HOLD: begin
        if (last) begin
          cnt_nxt   = is_long_cmd(rs_q, data_q) ? CW'(T_LONG) : CW'(T_SHORT);
          state_nxt = S_WAIT;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end

      S_WAIT: begin
        if (last) begin
          if (!done_q && idx != 2'(INIT_LEN - 1)) begin
            idx_nxt   = idx + 2'd1;
            state_nxt = S_INIT_LOAD;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end

      default: state_nxt = S_PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_PWRUP;
      cnt    <= CW'(T_PWRUP);
      idx    <= 2'd0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      en_q   <= 1'b0;
      gnt_q  <= 2'b00;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      rs_q   <= rs_nxt;
      data_q <= data_nxt;
      en_q   <= en_nxt;
      gnt_q  <= gnt_nxt;
      done_q <= done_nxt;
    end
  end

  assign bus.rs        = rs_q;
  assign bus.rw        = 1'b0;
  assign bus.enable    = en_q;
  assign bus.data      = data_q;
  assign bus.gnt       = gnt_q;
  assign bus.init_done = done_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// tb_lcd_bus_scheduler: scoreboard bench for lcd_bus_scheduler.
// Requester model issues bytes; every grant (and every init byte after a
// reset) pushes the expected LCD pulse, with its exact start cycle, into a
// queue. A negedge monitor pops and checks each enable pulse on the pins.
module tb_lcd_bus_scheduler;

  localparam int S   = 2;
  localparam int P   = 3;
  localparam int H   = 2;
  localparam int TS  = 10;
  localparam int TL  = 40;
  localparam int TPW = 50;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lcd_bus_scheduler_if bus();

  lcd_bus_scheduler #(
    .T_SETUP(S), .T_PULSE(P), .T_HOLD(H),
    .T_SHORT(TS), .T_LONG(TL), .T_PWRUP(TPW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;   // cycle on which enable must rise
  } exp_t;

  exp_t       sb[$];
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int rst_edge = -1;
  int init_done_exp = 0;
  int free_at = 0;       // cycle the bus re-enters IDLE
  int pend_since = 0;    // cycle the current pending request was first driven
  bit ptr_m = 1'b0;
  bit late = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input int act, input int expv);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Controller execution time: clear/home commands are long, all else short.
  function automatic int wait_len(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? TL : TS;
  endfunction

  task automatic drive();
    bus.req      = {q1.size() != 0, q0.size() != 0};
    bus.req_rs   = 2'b00;
    bus.req_data = 16'h0000;
    if (q0.size() != 0) begin
      bus.req_rs[0]      = q0[0][8];
      bus.req_data[7:0]  = q0[0][7:0];
    end
    if (q1.size() != 0) begin
      bus.req_rs[1]      = q1[0][8];
      bus.req_data[15:8] = q1[0][7:0];
    end
  endtask

  task automatic enq(input int i, input logic rs, input logic [7:0] d);
    if (bus.req == 2'b00) pend_since = cyc;
    if (i == 0) q0.push_back({rs, d});
    else        q1.push_back({rs, d});
    drive();
  endtask

  // Requester side: react to a grant seen this cycle, predict winner/time.
  task automatic service();
    logic [1:0] g, rq;
    logic [8:0] b;
    int expw, eg;
    bit got;
    if (reset) return;
    g  = bus.gnt;
    rq = bus.req;
    eg = ((pend_since > free_at) ? pend_since : free_at) + 1;
    if (g != 2'b00) begin
      expw = (rq == 2'b11) ? int'(ptr_m) : (rq[1] ? 1 : 0);
      chk(rq != 2'b00 && g == (2'b01 << expw), "gnt_winner", int'(g), 1 << expw);
      if (!late) chk(cyc == eg, "gnt_time", cyc, eg);
      late = 1'b0;
      got = 1'b0;
      b = 9'h000;
      if (g[1] && q1.size() != 0) begin b = q1.pop_front(); got = 1'b1; end
      else if (g[0] && q0.size() != 0) begin b = q0.pop_front(); got = 1'b1; end
      if (got) begin
        sb.push_back('{rs: b[8], data: b[7:0], rise: cyc + S});
        free_at = cyc + S + P + H + wait_len(b[8], b[7:0]);
      end
      ptr_m = (expw == 0);
      drive();
      pend_since = cyc;
    end else if (rq != 2'b00 && !late && cyc >= eg) begin
      chk(1'b0, "gnt_timeout", cyc, eg);
      late = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    service();
  endtask

  task automatic do_reset(input int n);
    logic [7:0] ib [4];
    int rise;
    ib[0] = 8'h38; ib[1] = 8'h0C; ib[2] = 8'h06; ib[3] = 8'h01;
    reset = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
    reset = 1'b0;
    rst_edge = cyc;
    sb.delete();
    q0.delete();
    q1.delete();
    drive();
    ptr_m = 1'b0;
    late = 1'b0;
    init_done_exp = rst_edge + TPW + 4 * (1 + S + P + H) + 3 * TS + TL;
    free_at = init_done_exp;
    rise = rst_edge + TPW + 1 + S;
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{rs: 1'b0, data: ib[k], rise: rise});
      rise += P + H + wait_len(1'b0, ib[k]) + 1 + S;
    end
    chk(bus.enable == 1'b0, "rst_enable", int'(bus.enable), 0);
    chk(bus.data == 8'h00, "rst_data", int'(bus.data), 0);
    chk(bus.rs == 1'b0, "rst_rs", int'(bus.rs), 0);
    chk(bus.rw == 1'b0, "rst_rw", int'(bus.rw), 0);
    chk(bus.gnt == 2'b00, "rst_gnt", int'(bus.gnt), 0);
    chk(bus.init_done == 1'b0, "rst_init_done", int'(bus.init_done), 0);
  endtask

  task automatic drain();
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || sb.size() != 0 || cyc < free_at) && k < 4000) begin
      step();
      k++;
    end
    if (k >= 4000) chk(1'b0, "drain_timeout", k, 4000);
  endtask

  // Monitor: every enable pulse must match the head of the scoreboard.
  logic [8:0] m_bus;
  logic       m_en, m_id;
  logic [1:0] m_gnt;
  int         m_pw;
  exp_t       m_e;

  always @(negedge clk) begin
    if (reset) begin
      m_pw = 0;
    end else if (cyc == rst_edge) begin
      m_bus = {bus.rs, bus.data};
      m_en  = bus.enable;
      m_gnt = bus.gnt;
      m_id  = bus.init_done;
      m_pw  = 0;
    end else begin
      // rs/data may only move on the SETUP-entry edge of the next pulse
      if ({bus.rs, bus.data} != m_bus)
        chk(sb.size() != 0 && cyc == sb[0].rise - S, "bus_change", cyc,
            (sb.size() != 0) ? sb[0].rise - S : -1);
      if (bus.enable && !m_en) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_pulse", int'({bus.rs, bus.data}), -1);
        end else begin
          m_e = sb.pop_front();
          chk(cyc == m_e.rise, "pulse_time", cyc, m_e.rise);
          chk({bus.rs, bus.data} == {m_e.rs, m_e.data}, "pulse_byte",
              int'({bus.rs, bus.data}), int'({m_e.rs, m_e.data}));
          chk(bus.rw == 1'b0, "rw_low", int'(bus.rw), 0);
        end
        m_pw = 1;
      end else if (bus.enable) begin
        m_pw++;
      end
      if (!bus.enable && m_en) chk(m_pw == P, "pulse_width", m_pw, P);
      if (sb.size() != 0 && cyc > sb[0].rise) begin
        chk(1'b0, "missing_pulse", cyc, sb[0].rise);
        void'(sb.pop_front());
      end
      if (bus.gnt != 2'b00 && m_gnt != 2'b00) chk(1'b0, "gnt_width", int'(bus.gnt), 0);
      if (bus.init_done != m_id)
        chk(bus.init_done && cyc == init_done_exp, "init_done_edge", cyc, init_done_exp);
      m_bus = {bus.rs, bus.data};
      m_en  = bus.enable;
      m_gnt = bus.gnt;
      m_id  = bus.init_done;
    end
  end

  initial begin
    bus.req = 2'b00;
    bus.req_rs = 2'b00;
    bus.req_data = 16'h0000;
    @(posedge clk);
    #2;
    do_reset(2);

    // request raised during PWRUP: waits for init, granted first IDLE cycle
    enq(0, 1'b1, 8'h41);
    drain();

    // single data byte after init
    enq(0, 1'b1, 8'h49);
    drain();

    // both requesters hold req: grants alternate
    for (int k = 0; k < 4; k++) begin
      enq(0, 1'b1, 8'h31);
      enq(1, 1'b1, 8'h32);
    end
    drain();

    // long and short command waits; data 8'h02 is not a command
    enq(1, 1'b0, 8'h01);
    enq(1, 1'b0, 8'h83);
    enq(0, 1'b1, 8'h02);
    enq(0, 1'b0, 8'h02);
    drain();

    // random traffic
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 2) == 0 && ((i == 0) ? q0.size() : q1.size()) < 3)
          enq(i, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) < 2) ? 8'($urandom_range(1, 3)) : 8'($urandom));
      end
      repeat ($urandom_range(1, 20)) step();
    end
    drain();

    // reset in the middle of an enable pulse
    enq(0, 1'b1, 8'h5A);
    for (int k = 0; k < 500 && !bus.enable; k++) step();
    chk(bus.enable == 1'b1, "reach_pulse", int'(bus.enable), 1);
    step();
    do_reset(1);
    enq(1, 1'b1, 8'h7E);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lcd_bus_scheduler.md
Name: lcd_bus_scheduler

Overview:
Owns the HD44780-style 8-bit LCD bus and shares it between two byte requesters, such as a static-label writer and a live-value writer. It runs the power-up init sequence itself and arbitrates requests round-robin. For each granted byte it drives RS/DATA with proper setup, enable-pulse and hold timing, then waits out the controller execution time. Requesters never touch rs/rw/enable/data directly.

Parameters:
T_SETUP, 5, clk cycles with rs/data stable before enable rises
T_PULSE, 25, clk cycles enable is held high
T_HOLD, 5, clk cycles rs/data held after enable falls
T_SHORT, 2500, execution wait after a normal command/data byte (50 us at 50 MHz)
T_LONG, 82000, execution wait after clear/home commands (1.64 ms)
T_PWRUP, 750000, delay after reset before the first init byte (15 ms)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  2  req[i]=1: requester i has a byte pending
req_rs  in  2  req_rs[i]: 0=command, 1=data, for requester i
req_data  in  16  byte for requester i at bits [8i+7:8i]
gnt  out  2  one-cycle acceptance pulse to requester i
init_done  out  1  high once the init sequence has finished
rs  out  1  LCD register select
rw  out  1  LCD read/write; always 0 (write-only)
enable  out  1  LCD E strobe
data  out  8  LCD D7..D0

Behaviour:
- The clock is one clock, clk. Reset is synchronous and active-high on port reset.
- All outputs are registered.
- Reset values: rs=0, rw=0, enable=0, data=8'h00, gnt=2'b00, init_done=0, rr pointer=0, state=PWRUP.
- States:
  - PWRUP: count T_PWRUP cycles, then go to INIT_LOAD with init index=0.
  - INIT_LOAD: load init byte[idx] with rs=0, then go to SETUP. The init bytes in order are 8'h38, 8'h0C, 8'h06, 8'h01.
  - IDLE: if init_done and |req, select a requester and go to SETUP; otherwise stay.
  - SETUP: T_SETUP cycles, enable=0.
  - PULSE: T_PULSE cycles, enable=1.
  - HOLD: T_HOLD cycles, enable=0.
  - WAIT: T_LONG cycles if the byte was a command 8'h01, 8'h02 or 8'h03; T_SHORT cycles otherwise. After WAIT, if the init sequence is still active and idx<3: idx+1, go to INIT_LOAD. If the last init byte has been sent: set init_done=1, go to IDLE. Otherwise go to IDLE.
- rs and data are loaded on the edge entering SETUP. They stay constant through SETUP, PULSE, HOLD and WAIT.
- Arbitration:
  - One requester asserting: it wins.
  - Both asserting: the requester pointed to by the rr pointer wins. The pointer then moves to the other requester.
  - A single grant also moves the pointer to the other requester.
- gnt[i] is high for exactly the first SETUP cycle of requester i's transaction. The operands have already been captured on the IDLE-to-SETUP edge.
- Requesters hold req, req_rs and req_data stable until they see gnt. They may drop req or present the next byte on the cycle after gnt.
- No new request is sampled outside IDLE, so one req can never be granted twice.
- Requests made before init_done=1 are not granted and not lost: they stay pending until IDLE is reached.
- Bus occupancy per byte is T_SETUP+T_PULSE+T_HOLD+wait cycles, plus 1 IDLE cycle. Minimum req-to-gnt latency from IDLE is 1 cycle.
- Counters are a single down-counter sized $clog2(max(T_PWRUP,T_LONG)+1). A counter reaching 1 ends its phase, so each phase lasts exactly its parameter count (parameters are at least 1).
- Reset mid-transaction: on the next edge, enable=0 and all outputs take their reset values. init_done drops to 0, and the full PWRUP plus init sequence repeats.

Decomposition:
- Package lcd_pkg holds:
  - command constants: LCD_FUNC_SET=8'h38, LCD_DISP_ON=8'h0C, LCD_ENTRY=8'h06, LCD_CLEAR=8'h01, LCD_HOME=8'h02, LCD_DDRAM=8'h80;
  - the state typedef;
  - an is_long_cmd(rs,data) function.
- Sub-module lcd_rr_arbiter handles the 2-way round-robin decision and pointer update, giving a one-hot grant.

Test Plan:
Run all scenarios with T_SETUP=2, T_PULSE=3, T_HOLD=2, T_SHORT=10, T_LONG=40, T_PWRUP=50.
- Reset, then idle: 50 cycles of PWRUP with enable=0. Then data=38,0C,06,01 in order with rs=0, each giving one 3-cycle enable pulse. Spacing is 2+3+2+10 cycles, and 40 cycles after 01. init_done rises after the last WAIT.
- After init, req=01 with req_rs[0]=1 and byte 8'h49 ("I"): gnt[0] appears 1 cycle later for 1 cycle. rs=1 and data=49 are stable, and enable is high for 3 cycles starting 2 cycles after gnt.
- Both requesters hold req (bytes 8'h31 and 8'h32, rs=1): grants alternate 0,1,0,1. There are no back-to-back grants to the same requester, and every transaction has full timing.
- Requester 1 sends command 8'h01 with rs=0: WAIT lasts 40 cycles. Command 8'h83 with rs=0 gets a 10-cycle WAIT.
- req[0] asserted during PWRUP: no gnt until init_done=1, then a grant in the first IDLE cycle with the byte unchanged.
- Assert reset for 1 cycle during PULSE: enable=0 and data=00 on the next edge, init_done=0, and the init sequence is replayed from PWRUP.
